bus_slot_scheduler: RTL and testbench
=====================================

Name: bus_slot_scheduler

Overview:
- Time-division scheduler for the shared system bus (address, data, rw and RAM strobes) at 16 MHz.
- Divides each 1 MHz CPU period into a 16-cycle frame with fixed slots for video fetch, one RPi/SPI access, and the 6502 access.
- Generates phi2, slot selects and RAM/IO strobes, and runs the pending/done handshake with the SPI bridge.
- Sits between the SPI bridge, the video block and the top-level bus muxing/chip-select logic.

Parameters:
- FRAME_CYCLES, 16, clocks per CPU cycle; fixed, and only 16 is supported. Elaboration fails otherwise.
- CPU_WR_LAST, 14, last frame cycle with cpu_write_o asserted; legal range 11..15.

Ports:
- clk_sys_i  in  1  16 MHz system clock
- reset_i  in  1  asynchronous, active-high reset
- bus_rw_n_i  in  1  CPU rw_b (1 = read)
- video_enable_i  in  1  1 = video fetch slot is active
- pi_pending_i  in  1  SPI bridge has a transaction waiting
- pi_rw_n_i  in  1  SPI transaction direction (1 = read)
- clk8_o  out  1  8 MHz pixel clock (cyc[0])
- phi2_o  out  1  CPU clock
- cpu_enable_o  out  1  CPU owns the bus
- cpu_read_o  out  1  CPU read strobe
- cpu_write_o  out  1  CPU write strobe
- io_read_o  out  1  late CPU read strobe used for keyboard intercept
- video_select_o  out  1  video owns the bus
- video_ram_strobe_o  out  1  latch character byte
- video_rom_strobe_o  out  1  latch glyph byte
- pi_select_o  out  1  RPi owns the bus
- pi_read_o  out  1  RPi read strobe; the falling edge latches read data
- pi_write_o  out  1  RPi write strobe
- pi_done_o  out  1  one-clock completion pulse

Behaviour:
- 4-bit frame counter cyc increments every clock and wraps 15 -> 0.
- Reset: cyc = 15 and every output = 0. The first edge after release enters cyc = 0.
- All outputs are registered and decoded from the next cyc value, so each output's value during cyc == n matches slot n below.
- Video slot, cyc 0-3, only when video_enable_i is sampled 1 at the edge entering cyc 0:
  - video_select_o is high for cyc 0-3.
  - video_ram_strobe_o is high at cyc 1 only.
  - video_rom_strobe_o is high at cyc 3 only.
  - If video_enable_i is 0, the slot is idle and all of these outputs stay 0.
- Pi slot, cyc 4-7, granted if pi_pending_i = 1 at the edge entering cyc 4:
  - pi_rw_n_i is latched at the grant.
  - pi_select_o is high for cyc 4-7.
  - pi_read_o (latched rw = 1) or pi_write_o (latched rw = 0) is high for cyc 5-6.
  - pi_done_o is high for cyc 7 only.
  - No grant means all Pi outputs stay 0 and no done pulse is issued.
- CPU slot, cyc 8-15:
  - phi2_o and cpu_enable_o are high for cyc 8-15 and low for cyc 0-7, giving a 50% duty cycle.
  - bus_rw_n_i is latched at the edge entering cyc 9.
  - Latched rw = 1: cpu_read_o is high for cyc 9-15 and io_read_o is high for cyc 12-15.
  - Latched rw = 0: cpu_write_o is high for cyc 11..CPU_WR_LAST.
- Slot outputs are mutually exclusive: at most one of video_select_o, pi_select_o and cpu_enable_o is high in any cycle.
- Handshake:
  - A pending request is accepted only at a grant edge.
  - pi_pending_i or pi_rw_n_i changing after the grant does not affect the transaction in flight.
  - The requester drops pending after pi_done_o. Pending still high at the next grant edge counts as a new request.
- Reset mid-frame: all outputs drop to 0 asynchronously.
  - An in-flight Pi transaction is abandoned with no done pulse; the requester retries.
  - On release, the frame restarts at cyc 0.
- Worst-case Pi latency from pending to done is 19 clocks; best case is 4.

Optional Feature:
- Macro PI_DOUBLE_SLOT_EN.
- Defined: when video_enable_i = 0 at the edge entering cyc 0, the idle video slot serves a Pi request instead.
  - Grant is sampled on that edge.
  - pi_select_o is high for cyc 0-3, the strobe is high for cyc 1-2, and pi_done_o is high for cyc 3.
  - The cyc 4 grant is then judged independently.
  - This allows up to 2 Pi accesses per frame.
- Undefined: the idle video slot remains unused, giving at most 1 Pi access per frame.

Test Plan:
- Release reset, hold all inputs at 0 and run 32 clocks.
  - phi2_o must read 0x00 for cyc 0-7 and 1 for cyc 8-15, repeating.
  - clk8_o must toggle every clock.
  - No strobes may assert.
- video_enable_i = 1 for 3 frames -> video_select_o is high for cyc 0-3, video_ram_strobe_o is high at cyc 1 and video_rom_strobe_o is high at cyc 3, in every frame.
- Pi handshake:
  - Raise pi_pending_i with pi_rw_n_i = 0 at cyc 2 -> pi_write_o high at cyc 5-6, pi_done_o high at cyc 7 only. Drop pending at cyc 8 -> no activity in the next frame.
  - Repeat with rw = 1 raised at cyc 5 -> grant occurs in the next frame and pi_done_o asserts exactly 18 clocks after pending rose.
- CPU strobes:
  - bus_rw_n_i = 0 -> cpu_write_o is high for cyc 11-14 only.
  - bus_rw_n_i = 1 -> cpu_read_o is high for cyc 9-15 and io_read_o for cyc 12-15.
  - Toggling bus_rw_n_i at cyc 10 has no effect on the current frame.
- Assert reset_i at cyc 6 of a granted Pi write:
  - All outputs go to 0 immediately and no pi_done_o is issued.
  - After release, cyc 0 follows the first edge, and the still-pending request completes with pi_done_o at cyc 7 of that frame.
- With PI_DOUBLE_SLOT_EN, video_enable_i = 0 and pending held high:
  - Two pi_done_o pulses per frame, at cyc 3 and cyc 7.
  - Without the macro, only the cyc 7 pulse occurs.

Source files
------------

// File: rtl/bus_slot_scheduler.sv
// 16-cycle bus frame: video (0-3), Pi (4-7), CPU (8-15); PI_DOUBLE_SLOT_EN lets Pi reuse an idle video slot.
// All outputs are registered from the next frame count; Pi requests that miss a grant edge wait for the next one.
module bus_slot_scheduler #(
  parameter int FRAME_CYCLES = 16,
  parameter int CPU_WR_LAST  = 14
) (
  input  logic clk_sys_i,
  input  logic reset_i,
  input  logic bus_rw_n_i,
  input  logic video_enable_i,
  input  logic pi_pending_i,
  input  logic pi_rw_n_i,
  output logic clk8_o,
  output logic phi2_o,
  output logic cpu_enable_o,
  output logic cpu_read_o,
  output logic cpu_write_o,
  output logic io_read_o,
  output logic video_select_o,
  output logic video_ram_strobe_o,
  output logic video_rom_strobe_o,
  output logic pi_select_o,
  output logic pi_read_o,
  output logic pi_write_o,
  output logic pi_done_o
);

  if (FRAME_CYCLES != 16) begin : g_frame_check
    $error("bus_slot_scheduler: FRAME_CYCLES must be 16");
  end
  if (CPU_WR_LAST < 11 || CPU_WR_LAST > 15) begin : g_wr_last_check
    $error("bus_slot_scheduler: CPU_WR_LAST must be 11..15");
  end

  localparam logic [3:0] WR_LAST = CPU_WR_LAST[3:0];

  logic [3:0] cyc, cyc_nxt;
  logic       vid_act, vid_act_nxt;
  logic       pi_act, pi_act_nxt;
  logic       pi_rw, pi_rw_nxt;
  logic       cpu_rw, cpu_rw_nxt;
  logic       pi_on, pi_strobe;

  always_comb begin
    cyc_nxt     = cyc + 4'd1;
    vid_act_nxt = vid_act;
    pi_act_nxt  = pi_act;
    pi_rw_nxt   = pi_rw;
    cpu_rw_nxt  = cpu_rw;
    if (cyc_nxt == 4'd0) begin
      vid_act_nxt = video_enable_i;
`ifdef PI_DOUBLE_SLOT_EN
      pi_act_nxt  = ~video_enable_i & pi_pending_i;
      pi_rw_nxt   = pi_rw_n_i;
`else
      pi_act_nxt  = 1'b0;
`endif
    end
    // Pi grant edge: request and direction are frozen for the whole slot
    if (cyc_nxt == 4'd4) begin
      pi_act_nxt = pi_pending_i;
      pi_rw_nxt  = pi_rw_n_i;
    end
    if (cyc_nxt == 4'd9) begin
      cpu_rw_nxt = bus_rw_n_i;
    end
  end

  // pi_act only ever holds a grant for the slot the frame is currently in
  assign pi_on     = pi_act_nxt & ~cyc_nxt[3];
  assign pi_strobe = cyc_nxt[1] ^ cyc_nxt[0];

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      cyc                <= 4'hF;
      vid_act            <= 1'b0;
      pi_act             <= 1'b0;
      pi_rw              <= 1'b0;
      cpu_rw             <= 1'b0;
      clk8_o             <= 1'b0;
      phi2_o             <= 1'b0;
      cpu_enable_o       <= 1'b0;
      cpu_read_o         <= 1'b0;
      cpu_write_o        <= 1'b0;
      io_read_o          <= 1'b0;
      video_select_o     <= 1'b0;
      video_ram_strobe_o <= 1'b0;
      video_rom_strobe_o <= 1'b0;
      pi_select_o        <= 1'b0;
      pi_read_o          <= 1'b0;
      pi_write_o         <= 1'b0;
      pi_done_o          <= 1'b0;
    end else begin
      cyc                <= cyc_nxt;
      vid_act            <= vid_act_nxt;
      pi_act             <= pi_act_nxt;
      pi_rw              <= pi_rw_nxt;
      cpu_rw             <= cpu_rw_nxt;
      clk8_o             <= cyc_nxt[0];
      phi2_o             <= cyc_nxt[3];
      cpu_enable_o       <= cyc_nxt[3];
      cpu_read_o         <= cpu_rw_nxt & (cyc_nxt >= 4'd9);
      cpu_write_o        <= ~cpu_rw_nxt & (cyc_nxt >= 4'd11) & (cyc_nxt <= WR_LAST);
      io_read_o          <= cpu_rw_nxt & (cyc_nxt >= 4'd12);
      video_select_o     <= vid_act_nxt & (cyc_nxt[3:2] == 2'b00);
      video_ram_strobe_o <= vid_act_nxt & (cyc_nxt == 4'd1);
      video_rom_strobe_o <= vid_act_nxt & (cyc_nxt == 4'd3);
      pi_select_o        <= pi_on;
      pi_read_o          <= pi_on & pi_rw_nxt & pi_strobe;
      pi_write_o         <= pi_on & ~pi_rw_nxt & pi_strobe;
      pi_done_o          <= pi_on & (cyc_nxt[1:0] == 2'b11);
    end
  end

endmodule

// File: tb/tb_bus_slot_scheduler.sv
// Bench for bus_slot_scheduler: fixed frame tables, handshake/reset sequences and random traffic vs a slot model.
module tb_bus_slot_scheduler;
  localparam int CPU_WR_LAST = 14;

  logic clk_sys_i = 1'b0;
  logic reset_i, bus_rw_n_i, video_enable_i, pi_pending_i, pi_rw_n_i;
  logic clk8_o, phi2_o, cpu_enable_o, cpu_read_o, cpu_write_o, io_read_o;
  logic video_select_o, video_ram_strobe_o, video_rom_strobe_o;
  logic pi_select_o, pi_read_o, pi_write_o, pi_done_o;

  bus_slot_scheduler #(.FRAME_CYCLES(16), .CPU_WR_LAST(CPU_WR_LAST)) dut (
    .clk_sys_i(clk_sys_i), .reset_i(reset_i), .bus_rw_n_i(bus_rw_n_i),
    .video_enable_i(video_enable_i), .pi_pending_i(pi_pending_i), .pi_rw_n_i(pi_rw_n_i),
    .clk8_o(clk8_o), .phi2_o(phi2_o), .cpu_enable_o(cpu_enable_o), .cpu_read_o(cpu_read_o),
    .cpu_write_o(cpu_write_o), .io_read_o(io_read_o), .video_select_o(video_select_o),
    .video_ram_strobe_o(video_ram_strobe_o), .video_rom_strobe_o(video_rom_strobe_o),
    .pi_select_o(pi_select_o), .pi_read_o(pi_read_o), .pi_write_o(pi_write_o),
    .pi_done_o(pi_done_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Output vector order: clk8 phi2 cpu_en cpu_rd cpu_wr io_rd | vsel vram vrom | psel prd pwr pdone
  typedef struct packed {
    logic ven, pend, pirw, busrw;
    logic [12:0] exp;
  } vec_t;
  vec_t tbl[32];

  // Frame-level model: position in frame plus the decisions taken at each grant edge
  int   m_pos;
  logic m_vid, m_pia, m_pia_rw, m_pib, m_pib_rw, m_cpurw;

  function automatic vec_t mk(input logic a, input logic b, input logic c, input logic d,
                              input logic [12:0] e);
    vec_t v;
    v.ven = a; v.pend = b; v.pirw = c; v.busrw = d; v.exp = e;
    return v;
  endfunction

  function automatic logic [12:0] dut_out();
    return {clk8_o, phi2_o, cpu_enable_o, cpu_read_o, cpu_write_o, io_read_o,
            video_select_o, video_ram_strobe_o, video_rom_strobe_o,
            pi_select_o, pi_read_o, pi_write_o, pi_done_o};
  endfunction

  function automatic logic [12:0] model_out();
    logic act, rw, ph;
    int rel;
    if (reset_i) return 13'd0;
    act = (m_pos < 4) ? m_pia : ((m_pos < 8) ? m_pib : 1'b0);
    rw  = (m_pos < 4) ? m_pia_rw : m_pib_rw;
    rel = m_pos % 4;
    ph  = (rel == 1) || (rel == 2);
    return {m_pos % 2 == 1, m_pos >= 8, m_pos >= 8, m_cpurw && m_pos >= 9,
            !m_cpurw && m_pos >= 11 && m_pos <= CPU_WR_LAST, m_cpurw && m_pos >= 12,
            m_vid && m_pos < 4, m_vid && m_pos == 1, m_vid && m_pos == 3,
            act, act && rw && ph, act && !rw && ph, act && rel == 3};
  endfunction

  task automatic model_reset();
    m_pos = 15; m_vid = 0; m_pia = 0; m_pia_rw = 0; m_pib = 0; m_pib_rw = 0; m_cpurw = 0;
  endtask

  task automatic model_step(input logic ven, input logic pend, input logic pirw, input logic busrw);
    m_pos = (m_pos + 1) % 16;
    if (m_pos == 0) begin
      m_vid = ven;
`ifdef PI_DOUBLE_SLOT_EN
      m_pia = !ven && pend;
      m_pia_rw = pirw;
`else
      m_pia = 1'b0;
`endif
    end
    if (m_pos == 4) begin m_pib = pend; m_pib_rw = pirw; end
    if (m_pos == 9) m_cpurw = busrw;
  endtask

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic tick(input logic ven, input logic pend, input logic pirw, input logic busrw);
    video_enable_i = ven; pi_pending_i = pend; pi_rw_n_i = pirw; bus_rw_n_i = busrw;
    @(posedge clk_sys_i);
    if (!reset_i) model_step(ven, pend, pirw, busrw);
    @(negedge clk_sys_i);
  endtask

  task automatic mtick(input string name, input logic ven, input logic pend, input logic pirw,
                       input logic busrw);
    tick(ven, pend, pirw, busrw);
    check(name, dut_out(), model_out());
  endtask

  initial begin
    int n, dones, done_pos;
    logic prev_clk8, got;

    // Frame 1: video on, Pi write, CPU read. Frame 2: video off, Pi read, CPU write, rw flips at cyc 10.
    tbl[0]  = mk(1, 1, 0, 1, 13'b000000_100_0000);
    tbl[1]  = mk(1, 1, 0, 1, 13'b100000_110_0000);
    tbl[2]  = mk(1, 1, 0, 1, 13'b000000_100_0000);
    tbl[3]  = mk(1, 1, 0, 1, 13'b100000_101_0000);
    tbl[4]  = mk(1, 1, 0, 1, 13'b000000_000_1000);
    tbl[5]  = mk(1, 1, 0, 1, 13'b100000_000_1010);
    tbl[6]  = mk(1, 1, 0, 1, 13'b000000_000_1010);
    tbl[7]  = mk(1, 1, 0, 1, 13'b100000_000_1001);
    tbl[8]  = mk(1, 1, 0, 1, 13'b011000_000_0000);
    tbl[9]  = mk(1, 1, 0, 1, 13'b111100_000_0000);
    tbl[10] = mk(1, 1, 0, 1, 13'b011100_000_0000);
    tbl[11] = mk(1, 1, 0, 1, 13'b111100_000_0000);
    tbl[12] = mk(1, 1, 0, 1, 13'b011101_000_0000);
    tbl[13] = mk(1, 1, 0, 1, 13'b111101_000_0000);
    tbl[14] = mk(1, 1, 0, 1, 13'b011101_000_0000);
    tbl[15] = mk(1, 1, 0, 1, 13'b111101_000_0000);
    tbl[16] = mk(0, 0, 1, 0, 13'b000000_000_0000);
    tbl[17] = mk(0, 1, 1, 0, 13'b100000_000_0000);
    tbl[18] = mk(0, 1, 1, 0, 13'b000000_000_0000);
    tbl[19] = mk(0, 1, 1, 0, 13'b100000_000_0000);
    tbl[20] = mk(0, 1, 1, 0, 13'b000000_000_1000);
    tbl[21] = mk(0, 1, 1, 0, 13'b100000_000_1100);
    tbl[22] = mk(0, 1, 1, 0, 13'b000000_000_1100);
    tbl[23] = mk(0, 1, 1, 0, 13'b100000_000_1001);
    tbl[24] = mk(0, 1, 1, 0, 13'b011000_000_0000);
    tbl[25] = mk(0, 1, 1, 0, 13'b111000_000_0000);
    tbl[26] = mk(0, 1, 1, 1, 13'b011000_000_0000);
    tbl[27] = mk(0, 1, 1, 1, 13'b111010_000_0000);
    tbl[28] = mk(0, 1, 1, 1, 13'b011010_000_0000);
    tbl[29] = mk(0, 1, 1, 1, 13'b111010_000_0000);
    tbl[30] = mk(0, 1, 1, 1, 13'b011010_000_0000);
    tbl[31] = mk(0, 1, 1, 1, 13'b111000_000_0000);

    reset_i = 1; video_enable_i = 0; pi_pending_i = 0; pi_rw_n_i = 0; bus_rw_n_i = 0;
    model_reset();
    repeat (3) @(posedge clk_sys_i);
    @(negedge clk_sys_i);
    check("reset_state", dut_out(), 13'd0);
    reset_i = 0;

    for (int i = 0; i < 32; i++) begin
      tick(tbl[i].ven, tbl[i].pend, tbl[i].pirw, tbl[i].busrw);
      check($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
    end

    for (int i = 0; i < 32; i++) begin
      prev_clk8 = clk8_o;
      mtick("idle", 0, 0, 0, 0);
      if (i % 8 == 0) check("clk8_toggle", {12'd0, clk8_o}, {12'd0, ~prev_clk8});
    end

    repeat (48) mtick("video", 1, 0, 0, 1);

    // Pi write raised at cyc 2, dropped at cyc 8
    while (m_pos != 2) mtick("align", 0, 0, 0, 1);
    dones = 0; done_pos = -1;
    while (m_pos != 8) begin
      mtick("pi_wr", 0, 1, 0, 1);
      if (pi_done_o) begin dones++; done_pos = m_pos; end
    end
    check_int("pi_wr_done_count", dones, 1);
    check_int("pi_wr_done_cyc", done_pos, 7);
    dones = 0;
    repeat (16) begin
      mtick("pi_after_drop", 0, 0, 0, 1);
      if (pi_select_o || pi_done_o) dones++;
    end
    check_int("pi_no_activity", dones, 0);

    // Pi read raised at cyc 5 misses this frame's grant
    while (m_pos != 5) mtick("align", 1, 0, 0, 1);
    n = 0; got = 0;
    while (!got && n < 40) begin
      mtick("pi_rd", 1, 1, 1, 1);
      n++;
      if (pi_done_o) got = 1;
    end
    check_int("pi_latency", n, 18);
    repeat (8) mtick("pi_rd_drop", 1, 0, 1, 1);

    // Reset during cyc 6 of a granted write
    while (m_pos != 3) mtick("align", 1, 0, 0, 1);
    while (m_pos != 6) mtick("pi_rst_wr", 1, 1, 0, 1);
    reset_i = 1;
    #1;
    model_reset();
    check("async_reset", dut_out(), 13'd0);
    tick(1, 1, 0, 1);
    check("reset_hold", dut_out(), 13'd0);
    reset_i = 0;
    n = 0; got = 0;
    while (!got && n < 40) begin
      mtick("pi_retry", 1, 1, 0, 1);
      n++;
      if (pi_done_o) got = 1;
    end
    check_int("retry_done_clocks", n, 8);
    repeat (8) mtick("retry_drop", 1, 0, 0, 1);

    // Idle video slot with pending held high
    while (m_pos != 15) mtick("align", 0, 0, 0, 1);
    dones = 0;
    repeat (32) begin
      mtick("dbl", 0, 1, 0, 1);
      if (pi_done_o) dones++;
    end
`ifdef PI_DOUBLE_SLOT_EN
    check_int("done_per_two_frames", dones, 4);
`else
    check_int("done_per_two_frames", dones, 2);
`endif
    repeat (4) mtick("dbl_drop", 0, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      mtick("random", 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
